// File: rtl/tx_ofdm_pkg.sv
// Shared constants for the OFDM transmit path: default symbol and prefix
// lengths, read-side FSM state encoding and CP_SEL code points.
package tx_ofdm_pkg;

    localparam int unsigned NFFT_DEF = 256;
    localparam int unsigned NCP_DEF  = 64;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_e;

    localparam logic [1:0] CP_SEL_DIV4  = 2'b00;
    localparam logic [1:0] CP_SEL_DIV8  = 2'b01;
    localparam logic [1:0] CP_SEL_DIV16 = 2'b10;
    localparam logic [1:0] CP_SEL_DIV32 = 2'b11;

    // Prefix length in samples for a CP_SEL code.
    function automatic int unsigned cp_len_from_sel(input logic [1:0] sel,
                                                    input int unsigned nfft);
        int unsigned len;
        case (sel)
            CP_SEL_DIV4:  len = nfft / 4;
            CP_SEL_DIV8:  len = nfft / 8;
            CP_SEL_DIV16: len = nfft / 16;
            default:      len = nfft / 32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/tx_cp_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output (the output register resets to zero).
module tx_cp_dpram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 9
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port.
    always_ff @(posedge CLK_I) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tx_cp_insert.sv
// Cyclic-prefix insertion between the IFFT (slave side) and the
// preamble/output stage (master side). Symbols are collected in a ping-pong
// buffer and replayed as the last cp_len samples followed by the whole symbol.
// Build option: define TX_CP_SEL_EN to add the CP_SEL port that selects the
// prefix length per symbol; otherwise the prefix length is NCP.
module tx_cp_insert
    import tx_ofdm_pkg::*;
#(
    parameter int unsigned NFFT = NFFT_DEF,
    parameter int unsigned NCP  = NCP_DEF
) (
`ifdef TX_CP_SEL_EN
    input  logic [1:0]  CP_SEL,
`endif
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

    localparam int unsigned AW = $clog2(NFFT);
    localparam int unsigned CW = AW + 1;

    logic          ena, writable, acc, wr_last;
    logic          wr_bank;
    logic [AW-1:0] wr_ptr;
    logic [1:0]    full, full_set, full_clr;

    rd_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n, cp_len, cp_len_n, cp_len_sel;
    logic          rd_bank, rd_bank_n, rd_done, issuing;
    logic [AW-1:0] rd_off;
    logic          out_halt, stb_n, cyc_drop;

    assign ena      = CYC_I & STB_I & WE_I;
    assign writable = ~RST_I & ~full[wr_bank];
    assign acc      = ena & writable;
    assign ACK_O    = acc;
    assign wr_last  = (wr_ptr == AW'(NFFT - 1));

    assign out_halt = STB_O & ~ACK_I;
    assign issuing  = (state != RD_IDLE);
    assign stb_n    = out_halt ? STB_O : issuing;
    assign cyc_drop = ~CYC_I & (full == 2'b00) & (state == RD_IDLE) & (~STB_O | ACK_I);
    assign WE_O     = STB_O;

`ifdef TX_CP_SEL_EN
    assign cp_len_sel = CW'(cp_len_from_sel(CP_SEL, NFFT));
`else
    assign cp_len_sel = CW'(NCP);
`endif

    // Write pointer and bank; a falling CYC_I discards a partial bank.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (!CYC_I) begin
            wr_ptr  <= '0;
        end else if (acc) begin
            if (wr_last) begin
                wr_ptr  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_ptr  <= wr_ptr + AW'(1);
            end
        end
    end

    // FULL set/clear requests; they always target different banks.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (acc && wr_last) begin
            full_set[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    // Per-bank FULL flags.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            full <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Read FSM next state, read offset and bank release; frozen while halted.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cp_len_n  = cp_len;
        rd_bank_n = rd_bank;
        rd_done   = 1'b0;
        // NFFT is a power of two, so (cnt - cp_len) mod NFFT == NFFT - cp_len + cnt.
        rd_off    = (state == RD_CP) ? (cnt[AW-1:0] - cp_len[AW-1:0]) : cnt[AW-1:0];
        if (!out_halt) begin
            case (state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        state_n  = RD_CP;
                        cnt_n    = '0;
                        cp_len_n = cp_len_sel;
                    end
                end
                RD_CP: begin
                    if (cnt == cp_len - CW'(1)) begin
                        state_n = RD_BODY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = cnt + CW'(1);
                    end
                end
                RD_BODY: begin
                    if (cnt == CW'(NFFT - 1)) begin
                        rd_done   = 1'b1;
                        rd_bank_n = ~rd_bank;
                        cnt_n     = '0;
                        if (full[~rd_bank]) begin
                            state_n  = RD_CP;
                            cp_len_n = cp_len_sel;
                        end else begin
                            state_n  = RD_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = RD_IDLE;
            endcase
        end
    end

    // Read FSM state register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= RD_IDLE;
            cnt     <= '0;
            cp_len  <= CW'(NCP);
            rd_bank <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cp_len  <= cp_len_n;
            rd_bank <= rd_bank_n;
        end
    end

    // Output strobe follows the RAM read latency; cycle spans the whole frame.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            STB_O <= 1'b0;
            CYC_O <= 1'b0;
        end else begin
            STB_O <= stb_n;
            if (stb_n) begin
                CYC_O <= 1'b1;
            end else if (cyc_drop) begin
                CYC_O <= 1'b0;
            end
        end
    end

    tx_cp_dpram #(
        .DW(32),
        .AW(AW + 1)
    ) u_ram (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .we      (acc),
        .wr_addr ({wr_bank, wr_ptr}),
        .wr_data (DAT_I),
        .rd_en   (issuing & ~out_halt),
        .rd_addr ({rd_bank, rd_off}),
        .rd_data (DAT_O)
    );

endmodule
